cfg_frame_writer: RTL and testbench

Configuration-side frame writer: consumes a 32-bit bitstream word stream and drives the `FrameData` row bus and one-hot `FrameStrobe` column bus that terminal and fabric tiles buffer and latch into their configuration frames. It sits at the fabric edge between the bitstream source (UART/SPI loader) and the tile array. It is the producing end of the `FrameStrobe`/`FrameData` interface the tiles receive.

---
 rtl/cfg_frame_pkg.sv | 22 ++
 rtl/cfg_strobe_decoder.sv | 41 ++++
 rtl/cfg_frame_writer.sv | 143 ++++++++++++++
 tb/tb_cfg_frame_writer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cfg_frame_pkg.sv
// Shared types and constants for the configuration frame writer.
// Holds the FSM state encoding, header field positions and default session words.
package cfg_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_STROBE = 2'd3
    } state_e;

    localparam int COL_MSB = 31;
    localparam int COL_LSB = 24;
    localparam int FRM_MSB = 7;
    localparam int FRM_LSB = 0;

    localparam int HDR_FIELD_W = COL_MSB - COL_LSB + 1;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_strobe_decoder.sv
// Registered one-hot decoder: (column, frame, fire) -> FrameStrobe, one cycle after fire.
// Output is all-zero whenever fire is low.
module cfg_strobe_decoder
    import cfg_frame_pkg::*;
#(
    parameter int NumColumns      = 4,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [HDR_FIELD_W-1:0]                col_i,
    input  logic [HDR_FIELD_W-1:0]                frame_i,
    input  logic                                  fire_i,
    output logic [MaxFramesPerCol*NumColumns-1:0] strobe_o
);

    logic [MaxFramesPerCol*NumColumns-1:0] strobe_d;
    logic [MaxFramesPerCol*NumColumns-1:0] strobe_q;

    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < NumColumns; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                strobe_d[c*MaxFramesPerCol+f] = fire_i
                    && (col_i == HDR_FIELD_W'(c))
                    && (frame_i == HDR_FIELD_W'(f));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/cfg_frame_writer.sv
// Bitstream word stream -> FrameData rows plus a one-cycle one-hot FrameStrobe per frame.
// CfgReady drops for one cycle per frame while the strobe is being issued.
module cfg_frame_writer
    import cfg_frame_pkg::*;
#(
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter int          NumRows         = 4,
    parameter int          NumColumns      = 4,
    parameter logic [31:0] SyncWord        = SYNC_WORD,
    parameter logic [31:0] DesyncWord      = DESYNC_WORD
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [31:0]                           CfgData,
    input  logic                                  CfgValid,
    output logic                                  CfgReady,
    output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
    output logic                                  ConfigActive,
    output logic [15:0]                           FrameCount,
    output logic                                  Error
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_e                             state_q, state_d;
    logic                               ready_q, ready_d;
    logic                               active_q, active_d;
    logic                               error_q, error_d;
    logic [15:0]                        count_q, count_d;
    logic [ROW_W-1:0]                   row_q, row_d;
    logic [HDR_FIELD_W-1:0]             col_q, col_d;
    logic [HDR_FIELD_W-1:0]             frm_q, frm_d;
    logic [FrameBitsPerRow*NumRows-1:0] data_q, data_d;

    logic                   accept;
    logic [HDR_FIELD_W-1:0] hdr_col;
    logic [HDR_FIELD_W-1:0] hdr_frm;

    assign accept  = CfgValid && ready_q;
    assign hdr_col = CfgData[COL_MSB:COL_LSB];
    assign hdr_frm = CfgData[FRM_MSB:FRM_LSB];

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        error_d  = error_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;
        frm_d    = frm_q;
        data_d   = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (CfgData == SyncWord)) begin
                    state_d  = ST_HEADER;
                    active_d = 1'b1;
                    count_d  = '0;
                    error_d  = 1'b0;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    if (CfgData == DesyncWord) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                    end else if ((int'(hdr_col) >= NumColumns) ||
                                 (int'(hdr_frm) >= MaxFramesPerCol)) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        error_d  = 1'b1;
                    end else begin
                        col_d   = hdr_col;
                        frm_d   = hdr_frm;
                        row_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = CfgData;
                    if (row_q == ROW_W'(NumRows - 1)) begin
                        state_d = ST_STROBE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                count_d = count_q + 16'd1;
                state_d = ST_HEADER;
            end
            default: state_d = ST_IDLE;
        endcase
        // Ready is registered, so it must already be low while the FSM sits in STROBE.
        ready_d = (state_d != ST_STROBE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            frm_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            error_q  <= error_d;
            count_q  <= count_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frm_q    <= frm_d;
            data_q   <= data_d;
        end
    end

    cfg_strobe_decoder #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe_dec (
        .clk_i    (CLK),
        .rst_i    (RST),
        .col_i    (col_q),
        .frame_i  (frm_q),
        .fire_i   (state_q == ST_STROBE),
        .strobe_o (FrameStrobe)
    );

    assign CfgReady     = ready_q;
    assign FrameData    = data_q;
    assign ConfigActive = active_q;
    assign FrameCount   = count_q;
    assign Error        = error_q;

endmodule

// File: tb/tb_cfg_frame_writer.sv
// Scoreboard bench for cfg_frame_writer: stimulus pushes expected strobes, a monitor pops them.
module tb_cfg_frame_writer;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [31:0]  CfgData = '0;
    logic         CfgValid = 1'b0;
    logic         CfgReady;
    logic [127:0] FrameData;
    logic [79:0]  FrameStrobe;
    logic         ConfigActive;
    logic [15:0]  FrameCount;
    logic         Error;

    cfg_frame_writer dut (
        .CLK          (CLK),
        .RST          (RST),
        .CfgData      (CfgData),
        .CfgValid     (CfgValid),
        .CfgReady     (CfgReady),
        .FrameData    (FrameData),
        .FrameStrobe  (FrameStrobe),
        .ConfigActive (ConfigActive),
        .FrameCount   (FrameCount),
        .Error        (Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int           idx;
        logic [127:0] data;
        logic [15:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   strobes_seen = 0;
    logic prev_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe cycle must match the oldest expected frame.
    always @(negedge CLK) begin
        if (!RST && FrameStrobe != '0) begin
            strobes_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=%0h required=0", FrameStrobe);
            end else begin
                exp_t e;
                logic [79:0] onehot;
                e = sb.pop_front();
                onehot = '0;
                onehot[e.idx] = 1'b1;
                check("strobe_bits", {48'd0, FrameStrobe}, {48'd0, onehot});
                check("frame_data", FrameData, e.data);
                check("frame_count", {112'd0, FrameCount}, {112'd0, e.cnt});
                check("ready_low_before_strobe", {127'd0, prev_ready}, 128'd0);
            end
        end
        prev_ready <= CfgReady;
    end

    // Caller sits at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [31:0] w);
        int n;
        CfgValid = 1'b1;
        CfgData  = w;
        n = 0;
        while (!CfgReady && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!CfgReady) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(negedge CLK);
        CfgValid = 1'b0;
    endtask

    task automatic gap(input bit en);
        if (en) repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic frame(input logic [7:0] col, input logic [7:0] frm,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic [15:0] cnt, input bit gaps);
        exp_t e;
        e.idx  = int'(col) * 20 + int'(frm);
        e.data = {d3, d2, d1, d0};
        e.cnt  = cnt;
        send({col, 16'h0000, frm}); gap(gaps);
        send(d0); gap(gaps);
        send(d1); gap(gaps);
        send(d2); gap(gaps);
        sb.push_back(e);
        send(d3); gap(gaps);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"}, FrameData, 128'd0);
        check({name, "_strobe"}, {48'd0, FrameStrobe}, 128'd0);
        check({name, "_flags"}, {125'd0, CfgReady, ConfigActive, Error}, 128'd0);
        check({name, "_count"}, {112'd0, FrameCount}, 128'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_reset", {127'd0, CfgReady}, 128'd1);

        // Garbage before sync is dropped.
        send(32'h1234_5678);
        @(negedge CLK);
        check("garbage_active", {127'd0, ConfigActive}, 128'd0);

        send(32'hFAB0_FAB1);
        check("sync_active", {127'd0, ConfigActive}, 128'd1);
        frame(8'd2, 8'd5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 16'd1, 1'b0);
        repeat (3) @(negedge CLK);
        check("data_holds", FrameData, 128'h44444444_33333333_22222222_11111111);
        check("count_after_frame", {112'd0, FrameCount}, 128'd1);

        // Column out of range.
        send(32'h0400_0000);
        @(negedge CLK);
        check("bad_col_error", {127'd0, Error}, 128'd1);
        check("bad_col_active", {127'd0, ConfigActive}, 128'd0);
        send(32'h0000_0001);
        send(32'hFAB0_FAB1);
        check("sync_clears_error", {126'd0, Error, ConfigActive}, 128'd1);
        check("sync_clears_count", {112'd0, FrameCount}, 128'd0);

        // Frame out of range.
        send(32'h0000_0014);
        check("bad_frm_error", {126'd0, Error, ConfigActive}, 128'd2);
        send(32'hFAB0_FAB1);

        // Two back-to-back frames with random valid gaps.
        frame(8'd3, 8'd19, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 16'd1, 1'b1);
        frame(8'd0, 8'd0, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10, 16'd2, 1'b1);
        repeat (3) @(negedge CLK);

        // Desync closes the session and keeps the count.
        send(32'hFFFF_FFFF);
        check("desync_active", {127'd0, ConfigActive}, 128'd0);
        check("desync_count", {112'd0, FrameCount}, 128'd2);

        // Reset in the middle of a frame.
        send(32'hFAB0_FAB1);
        send(32'h0100_0001);
        send(32'hDEAD_0001);
        send(32'hDEAD_0002);
        RST = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_midreset", {127'd0, CfgReady}, 128'd1);
        send(32'hDEAD_0003);
        send(32'hDEAD_0004);
        send(32'h0100_0001);
        repeat (4) @(negedge CLK);
        check("no_session_after_reset", {127'd0, ConfigActive}, 128'd0);

        check("strobe_pulses", 128'(strobes_seen), 128'd3);
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
